// File: rtl/operand_register_file.sv
// Operand register file feeding the ALU A/B inputs.
// Eight 16-bit registers (R1-R4 general purpose, S1-S4 scratch), each a
// loadable up/down counter. Every enabled register applies the shared FunSel
// operation to its own current value on the same edge. Reads are purely
// combinational, so a port shows the old value during the write cycle and
// the new value after the edge.
module operand_register_file #(
    parameter int WIDTH   = 16,
    parameter int NUM_GP  = 4,
    parameter int NUM_SCR = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   I,
    input  logic [2:0]         FunSel,
    input  logic [NUM_GP-1:0]  RegSel,
    input  logic [NUM_SCR-1:0] ScrSel,
    input  logic [2:0]         OutASel,
    input  logic [2:0]         OutBSel,
    output logic [WIDTH-1:0]   OutA,
    output logic [WIDTH-1:0]   OutB
);

    localparam int NUM_REGS = NUM_GP + NUM_SCR;

    localparam logic [2:0] FS_DEC    = 3'b000;
    localparam logic [2:0] FS_INC    = 3'b001;
    localparam logic [2:0] FS_LOAD   = 3'b010;
    localparam logic [2:0] FS_CLR    = 3'b011;
    localparam logic [2:0] FS_CLR_LO = 3'b100;
    localparam logic [2:0] FS_WR_LO  = 3'b101;
    localparam logic [2:0] FS_WR_HI  = 3'b110;
    localparam logic [2:0] FS_SEXT   = 3'b111;

    // Index 0-3 = R1-R4, 4-7 = S1-S4; matches the OutASel/OutBSel encoding.
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] en;

    assign en = {ScrSel, RegSel};

    // Next value of one register for a given operation. Byte operations touch
    // bits [7:0] and [15:8]; anything above bit 15 only matters for SEXT/CLR.
    function automatic logic [WIDTH-1:0] next_val(
        input logic [2:0]       fs,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] q_n;
        q_n = q;
        case (fs)
            FS_DEC:    q_n = q - WIDTH'(1);
            FS_INC:    q_n = q + WIDTH'(1);
            FS_LOAD:   q_n = d;
            FS_CLR:    q_n = '0;
            FS_CLR_LO: begin
                q_n      = '0;
                q_n[7:0] = d[7:0];
            end
            FS_WR_LO:  q_n[7:0]  = d[7:0];
            FS_WR_HI:  q_n[15:8] = d[7:0];
            FS_SEXT:   q_n = {{(WIDTH-8){d[7]}}, d[7:0]};
            default:   q_n = q;
        endcase
        return q_n;
    endfunction

    // Register array: async clear, otherwise each enabled entry takes the op.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (en[k]) begin
                    regs[k] <= next_val(FunSel, regs[k], I);
                end
            end
        end
    end

    // Combinational read ports, no bypass from I.
    always_comb begin
        OutA = regs[OutASel];
        OutB = regs[OutBSel];
    end

endmodule

// File: tb/tb_operand_register_file.sv
// Self-checking bench for operand_register_file: reset, table-driven directed
// vectors, hand-written timing sequences and randomized traffic against a
// behavioural model of the eight registers.
module tb_operand_register_file;

    logic        Clock;
    logic        Reset;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [15:0] OutA;
    logic [15:0] OutB;

    int passed = 0;
    int total  = 0;

    int model [8];

    typedef struct {
        bit          do_edge;
        logic [2:0]  fs;
        logic [3:0]  rs;
        logic [3:0]  ss;
        logic [15:0] i;
        logic [2:0]  sel;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [$];

    operand_register_file dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic int ref_op(input int fs, input int q, input int d);
        int lo;
        lo = d % 256;
        case (fs)
            0: return (q + 65535) % 65536;
            1: return (q + 1) % 65536;
            2: return d;
            3: return 0;
            4: return lo;
            5: return (q / 256) * 256 + lo;
            6: return lo * 256 + (q % 256);
            default: return (lo >= 128) ? 65280 + lo : lo;
        endcase
    endfunction

    // One clocked operation; enables are dropped right after the edge.
    task automatic step(input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss,
                        input logic [15:0] d);
        logic [7:0] en;
        @(negedge Clock);
        FunSel = fs; RegSel = rs; ScrSel = ss; I = d;
        en = {ss, rs};
        @(posedge Clock);
        for (int k = 0; k < 8; k++)
            if (en[k]) model[k] = ref_op(int'(fs), model[k], int'(d));
        #1;
        RegSel = 4'b0000; ScrSel = 4'b0000;
    endtask

    // Reads every register through both ports; enables are zero so edges are harmless.
    task automatic check_all(input string tag);
        for (int k = 0; k < 8; k++) begin
            OutASel = 3'(k);
            OutBSel = 3'(7 - k);
            #1;
            check($sformatf("%s_A%0d", tag, k), OutA, 16'(model[k]));
            check($sformatf("%s_B%0d", tag, 7 - k), OutB, 16'(model[7 - k]));
        end
    endtask

    initial begin
        Reset = 1'b0; I = '0; FunSel = '0; RegSel = '0; ScrSel = '0;
        OutASel = '0; OutBSel = '0;
        for (int k = 0; k < 8; k++) model[k] = 0;

        // Table: R2 wrap, S3 byte ops, multi-enable inc, low-byte clear, clear.
        vecs.push_back('{1'b1, 3'b000, 4'b0010, 4'b0000, 16'h0000, 3'd1, 16'hFFFF});
        vecs.push_back('{1'b1, 3'b001, 4'b0010, 4'b0000, 16'h0000, 3'd1, 16'h0000});
        vecs.push_back('{1'b1, 3'b001, 4'b0010, 4'b0000, 16'h0000, 3'd1, 16'h0001});
        vecs.push_back('{1'b1, 3'b010, 4'b0000, 4'b0100, 16'h5566, 3'd6, 16'h5566});
        vecs.push_back('{1'b1, 3'b101, 4'b0000, 4'b0100, 16'h12AB, 3'd6, 16'h55AB});
        vecs.push_back('{1'b1, 3'b110, 4'b0000, 4'b0100, 16'h12AB, 3'd6, 16'hABAB});
        vecs.push_back('{1'b1, 3'b111, 4'b0000, 4'b0100, 16'h0080, 3'd6, 16'hFF80});
        vecs.push_back('{1'b1, 3'b010, 4'b0001, 4'b0000, 16'h0003, 3'd0, 16'h0003});
        vecs.push_back('{1'b1, 3'b010, 4'b1000, 4'b0000, 16'h0010, 3'd3, 16'h0010});
        vecs.push_back('{1'b1, 3'b010, 4'b0000, 4'b0001, 16'h7FFF, 3'd4, 16'h7FFF});
        vecs.push_back('{1'b1, 3'b001, 4'b1001, 4'b0001, 16'h0000, 3'd0, 16'h0004});
        vecs.push_back('{1'b0, 3'b000, 4'b0000, 4'b0000, 16'h0000, 3'd3, 16'h0011});
        vecs.push_back('{1'b0, 3'b000, 4'b0000, 4'b0000, 16'h0000, 3'd4, 16'h8000});
        vecs.push_back('{1'b0, 3'b000, 4'b0000, 4'b0000, 16'h0000, 3'd1, 16'h0001});
        vecs.push_back('{1'b0, 3'b000, 4'b0000, 4'b0000, 16'h0000, 3'd2, 16'h0000});
        vecs.push_back('{1'b1, 3'b100, 4'b0100, 4'b0000, 16'hABCD, 3'd2, 16'h00CD});
        vecs.push_back('{1'b1, 3'b011, 4'b0010, 4'b0000, 16'hFFFF, 3'd1, 16'h0000});
        vecs.push_back('{1'b1, 3'b111, 4'b0000, 4'b1000, 16'h347F, 3'd7, 16'h007F});
        vecs.push_back('{1'b1, 3'b000, 4'b0000, 4'b1000, 16'h0000, 3'd7, 16'h007E});

        repeat (2) @(negedge Clock);
        check_all("reset_state");
        @(negedge Clock);
        Reset = 1'b1;

        foreach (vecs[n]) begin
            if (vecs[n].do_edge) step(vecs[n].fs, vecs[n].rs, vecs[n].ss, vecs[n].i);
            OutASel = vecs[n].sel;
            OutBSel = vecs[n].sel;
            #1;
            check($sformatf("vec%0d_A", n), OutA, vecs[n].exp);
            check($sformatf("vec%0d_B", n), OutB, vecs[n].exp);
        end
        check_all("after_table");

        // T1: fill with FFFF, assert reset mid-cycle with enables active.
        step(3'b010, 4'b1111, 4'b1111, 16'hFFFF);
        check_all("filled");
        @(negedge Clock);
        #2;
        FunSel = 3'b001; RegSel = 4'b1111; ScrSel = 4'b1111;
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) model[k] = 0;
        #1;
        OutASel = 3'd0; OutBSel = 3'd7;
        #1;
        check("async_reset_A", OutA, 16'h0000);
        check("async_reset_B", OutB, 16'h0000);
        @(posedge Clock);
        #1;
        RegSel = 4'b0000; ScrSel = 4'b0000;
        check_all("reset_held");
        @(negedge Clock);
        Reset = 1'b1;
        step(3'b001, 4'b0001, 4'b0000, 16'h0000);
        OutASel = 3'd0;
        #1;
        check("first_update_after_reset", OutA, 16'h0001);

        // T5: read-old/write-new on both ports selecting the same register.
        step(3'b010, 4'b0001, 4'b0000, 16'h1234);
        @(negedge Clock);
        OutASel = 3'd0; OutBSel = 3'd0;
        I = 16'hBEEF; FunSel = 3'b010; RegSel = 4'b0001; ScrSel = 4'b0000;
        #1;
        check("write_cycle_old_A", OutA, 16'h1234);
        check("write_cycle_old_B", OutB, 16'h1234);
        @(posedge Clock);
        #1;
        RegSel = 4'b0000;
        model[0] = 16'hBEEF;
        check("after_edge_new_A", OutA, 16'hBEEF);
        check("after_edge_new_B", OutB, 16'hBEEF);

        // T6: no enables, every FunSel, random data -> nothing changes.
        step(3'b010, 4'b1111, 4'b1111, 16'h5A5A);
        step(3'b001, 4'b0101, 4'b1010, 16'h0000);
        for (int f = 0; f < 8; f++) step(3'(f), 4'b0000, 4'b0000, 16'($urandom));
        check_all("hold");

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            step(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 16'($urandom));
            OutASel = 3'($urandom_range(0, 7));
            OutBSel = 3'($urandom_range(0, 7));
            #1;
            check($sformatf("rand%0d_A", n), OutA, 16'(model[OutASel]));
            check($sformatf("rand%0d_B", n), OutB, 16'(model[OutBSel]));
        end
        check_all("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
